// File: rtl/l2_cache_pkg.sv
// l2_cache_pkg: shared constants and FSM state type for the L2 cache
package l2_cache_pkg;
  localparam int LINE_W = 512;
  localparam int SUB_W = 128;
  localparam int N_SUB = LINE_W / SUB_W;
  localparam logic [3:0] MEM_LW = 4'd4;
  localparam logic [3:0] MEM_SW = 4'd7;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP, FL_RD, FL_WB} l2_state_t;
endpackage

// File: rtl/l2_cache_tag_data_ram.sv
// l2_tag_data_ram: sync-read tag and line storage with per-sub-block write enables
import l2_cache_pkg::*;
module l2_tag_data_ram #(
  parameter int IDX_W = 8,
  parameter int TAG_W = 18
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [N_SUB-1:0]  wr_sub,
  input  logic [LINE_W-1:0] wr_data
);
  logic [TAG_W-1:0] tag_mem [2**IDX_W];
  logic [N_SUB-1:0][SUB_W-1:0] data_mem [2**IDX_W];
  // read output holds between reads so victim data stays stable during writeback
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_tag <= tag_mem[rd_idx];
      rd_data <= data_mem[rd_idx];
    end
    if (wr_en) begin
      tag_mem[wr_idx] <= wr_tag;
      for (int s = 0; s < N_SUB; s++)
        if (wr_sub[s]) data_mem[wr_idx][s] <= wr_data[s*SUB_W +: SUB_W];
    end
  end
endmodule

// File: rtl/l2_cache.sv
// l2_cache: direct-mapped write-back L2 serving L1I/L1D line traffic and sequencing hierarchy flush
import l2_cache_pkg::*;
module l2_cache #(
  parameter int M_WIDTH = 32,
  parameter int LG_L2_LINES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               l1d_req,
  input  logic               l1i_req,
  input  logic [M_WIDTH-1:0] l1d_addr,
  input  logic [M_WIDTH-1:0] l1i_addr,
  input  logic [3:0]         l1d_opcode,
  input  logic [SUB_W-1:0]   l1_mem_req_store_data,
  output logic               l1_mem_req_ack,
  output logic               l1d_rsp_valid,
  output logic               l1i_rsp_valid,
  output logic [SUB_W-1:0]   l1_mem_load_data,
  input  logic               l1d_flush_req,
  input  logic               l1i_flush_req,
  input  logic               l1d_flush_complete,
  input  logic               l1i_flush_complete,
  output logic               flush_complete,
  output logic               mem_req_valid,
  output logic [M_WIDTH-1:0] mem_req_addr,
  output logic [LINE_W-1:0]  mem_req_store_data,
  output logic [3:0]         mem_req_opcode,
  input  logic               mem_rsp_valid,
  input  logic [LINE_W-1:0]  mem_rsp_load_data,
  output logic [63:0]        cache_accesses,
  output logic [63:0]        cache_hits
);
  localparam int IDX_W = LG_L2_LINES;
  localparam int TAG_W = M_WIDTH - IDX_W - 6;
  l2_state_t state, state_n;
  logic pend_d, pend_i, need_d, need_i, flush_pend, d_wr, cur_wr, cur_d;
  logic [M_WIDTH-1:0] d_addr, i_addr, cur_addr;
  logic [SUB_W-1:0] d_data, cur_data;
  logic [2**IDX_W-1:0] valid_q, dirty_q;
  logic [IDX_W-1:0] scan, cur_idx, sel_idx;
  logic [TAG_W-1:0] cur_tag, rd_tag;
  logic [1:0] cur_sb;
  logic [LINE_W-1:0] line_q, rd_data;
  logic accept, flush_go, hit, fl_dirty, fl_adv, unused_ok;
  assign cur_idx = cur_addr[IDX_W+5:6];
  assign cur_tag = cur_addr[M_WIDTH-1:IDX_W+6];
  assign cur_sb = cur_addr[5:4];
  assign unused_ok = ^cur_addr[3:0];
  assign sel_idx = pend_d ? d_addr[IDX_W+5:6] : i_addr[IDX_W+5:6];
  assign accept = state == IDLE && (pend_d || pend_i);
  assign flush_go = state == IDLE && !pend_d && !pend_i && flush_pend && !need_d && !need_i;
  assign hit = valid_q[cur_idx] && rd_tag == cur_tag;
  assign fl_dirty = valid_q[scan] && dirty_q[scan];
  assign fl_adv = state == FL_WB && (!fl_dirty || mem_rsp_valid);
  l2_tag_data_ram #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_ram (
    .clk(clk),
    .rd_en(accept || state == FL_RD),
    .rd_idx(state == FL_RD ? scan : sel_idx),
    .rd_tag(rd_tag),
    .rd_data(rd_data),
    .wr_en((state == FILL && mem_rsp_valid) || (state == RESP && cur_wr)),
    .wr_idx(cur_idx),
    .wr_tag(cur_tag),
    .wr_sub(state == FILL ? {N_SUB{1'b1}} : N_SUB'(1) << cur_sb),
    .wr_data(state == FILL ? mem_rsp_load_data : {N_SUB{cur_data}})
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? LOOKUP : flush_go ? FL_RD : IDLE;
      LOOKUP:  state_n = hit ? RESP : (valid_q[cur_idx] && dirty_q[cur_idx]) ? WB : FILL;
      WB:      state_n = mem_rsp_valid ? FILL : WB;
      FILL:    state_n = mem_rsp_valid ? RESP : FILL;
      FL_RD:   state_n = FL_WB;
      FL_WB:   state_n = !fl_adv ? FL_WB : &scan ? IDLE : FL_RD;
      default: state_n = IDLE;
    endcase
  end
  // outputs are gated to zero whenever their valid is low, so reset leaves every output 0
  assign mem_req_valid = state == WB || state == FILL || (state == FL_WB && fl_dirty);
  assign mem_req_opcode = !mem_req_valid ? 4'd0 : state == FILL ? MEM_LW : MEM_SW;
  assign mem_req_addr = !mem_req_valid ? '0 : state == FILL ? {cur_addr[M_WIDTH-1:6], 6'b0}
                      : {rd_tag, state == WB ? cur_idx : scan, 6'b0};
  assign mem_req_store_data = (mem_req_valid && state != FILL) ? rd_data : '0;
  assign l1_mem_req_ack = accept;
  assign l1d_rsp_valid = state == RESP && cur_d;
  assign l1i_rsp_valid = state == RESP && !cur_d;
  assign l1_mem_load_data = (state == RESP && !cur_wr) ? line_q[cur_sb*SUB_W +: SUB_W] : '0;
  assign flush_complete = fl_adv && &scan;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      {pend_d, pend_i, need_d, need_i, flush_pend, d_wr, cur_wr, cur_d} <= '0;
      {d_addr, i_addr, cur_addr, d_data, cur_data} <= '0;
    end else begin
      state <= state_n;
      if (l1d_req) {pend_d, d_addr, d_wr, d_data} <= {1'b1, l1d_addr, l1d_opcode == MEM_SW, l1_mem_req_store_data};
      else if (accept && pend_d) pend_d <= 1'b0;
      if (l1i_req) {pend_i, i_addr} <= {1'b1, l1i_addr};
      else if (accept && !pend_d) pend_i <= 1'b0;
      need_d <= (need_d || l1d_flush_req) && !l1d_flush_complete;
      need_i <= (need_i || l1i_flush_req) && !l1i_flush_complete;
      if (l1d_flush_req || l1i_flush_req) flush_pend <= 1'b1;
      else if (flush_go) flush_pend <= 1'b0;
      if (accept) {cur_d, cur_addr, cur_wr, cur_data} <= {pend_d, pend_d ? d_addr : i_addr, pend_d && d_wr, d_data};
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {valid_q, dirty_q, scan, cache_accesses, cache_hits} <= '0;
      line_q <= '0;
    end else begin
      if (accept) cache_accesses <= cache_accesses + 64'd1;
      if (state == LOOKUP) line_q <= rd_data;
      if (state == LOOKUP && hit) cache_hits <= cache_hits + 64'd1;
      if (state == FILL && mem_rsp_valid) {line_q, valid_q[cur_idx], dirty_q[cur_idx]} <= {mem_rsp_load_data, 2'b10};
      if (state == RESP && cur_wr) dirty_q[cur_idx] <= 1'b1;
      if (flush_go) scan <= '0;
      if (fl_adv) {valid_q[scan], dirty_q[scan], scan} <= {2'b00, scan + 1'b1};
    end
  end
endmodule

// File: tb/tb_l2_cache.sv
// tb_l2_cache: scoreboard bench with a memory responder and directed L1/flush traffic
module tb_l2_cache;
  import l2_cache_pkg::*;
  logic clk = 0, reset = 0;
  logic l1d_req = 0, l1i_req = 0, l1d_flush_req = 0, l1i_flush_req = 0;
  logic l1d_flush_complete = 0, l1i_flush_complete = 0, mem_rsp_valid = 0;
  logic [31:0] l1d_addr = 0, l1i_addr = 0;
  logic [3:0] l1d_opcode = 0;
  logic [127:0] l1_mem_req_store_data = 0;
  logic [511:0] mem_rsp_load_data = 0;
  logic l1_mem_req_ack, l1d_rsp_valid, l1i_rsp_valid, flush_complete, mem_req_valid;
  logic [127:0] l1_mem_load_data;
  logic [31:0] mem_req_addr;
  logic [511:0] mem_req_store_data;
  logic [3:0] mem_req_opcode;
  logic [63:0] cache_accesses, cache_hits;

  typedef struct {logic d; logic chk; logic [127:0] data;} rsp_t;
  typedef struct {logic [31:0] addr; logic [3:0] op; logic chk; logic [1:0] sb; logic [127:0] data;} mreq_t;
  rsp_t exp_rsp[$];
  mreq_t exp_mem[$];
  logic [511:0] mem_model [logic [31:0]];
  int checks = 0, errors = 0, fc_cnt = 0;
  logic mem_block = 0;

  localparam logic [127:0] SB0_1000 = 128'h00001003_00001002_00001001_00001000;
  localparam logic [127:0] SB1_1000 = 128'h00001007_00001006_00001005_00001004;
  localparam logic [127:0] SB3_1000 = 128'h0000100f_0000100e_0000100d_0000100c;
  localparam logic [127:0] SB0_5000 = 128'h00005003_00005002_00005001_00005000;
  localparam logic [127:0] SB0_2000 = 128'h00002003_00002002_00002001_00002000;
  localparam logic [127:0] AA = {16{8'hAA}};
  localparam logic [127:0] BB = {16{8'hBB}};
  localparam logic [127:0] CC = {16{8'hCC}};

  always #5 clk = ~clk;

  l2_cache dut (
    .clk(clk), .reset(reset),
    .l1d_req(l1d_req), .l1i_req(l1i_req), .l1d_addr(l1d_addr), .l1i_addr(l1i_addr),
    .l1d_opcode(l1d_opcode), .l1_mem_req_store_data(l1_mem_req_store_data),
    .l1_mem_req_ack(l1_mem_req_ack), .l1d_rsp_valid(l1d_rsp_valid), .l1i_rsp_valid(l1i_rsp_valid),
    .l1_mem_load_data(l1_mem_load_data),
    .l1d_flush_req(l1d_flush_req), .l1i_flush_req(l1i_flush_req),
    .l1d_flush_complete(l1d_flush_complete), .l1i_flush_complete(l1i_flush_complete),
    .flush_complete(flush_complete),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_store_data(mem_req_store_data),
    .mem_req_opcode(mem_req_opcode), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_load_data(mem_rsp_load_data),
    .cache_accesses(cache_accesses), .cache_hits(cache_hits)
  );

  function automatic void check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [511:0] pattern(input logic [31:0] a);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = {a[31:6], 6'b0} + 32'(k);
    return l;
  endfunction

  function automatic void exp_r(input logic d, input logic chk, input logic [127:0] data);
    exp_rsp.push_back('{d, chk, data});
  endfunction

  function automatic void exp_m(input logic [31:0] a, input logic [3:0] op, input logic chk,
                                input logic [1:0] sb, input logic [127:0] data);
    exp_mem.push_back('{a, op, chk, sb, data});
  endfunction

  // memory responder: checks each new request against the queue, answers 3 cycles later
  initial begin : responder
    bit seen;
    int cnt;
    mreq_t e;
    logic [31:0] a;
    seen = 0;
    cnt = 0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 0;
      if (!mem_req_valid) seen = 0;
      else if (!seen) begin
        seen = 1;
        cnt = 0;
        if (exp_mem.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_unexpected got addr %0h op %0d expected no request", mem_req_addr, mem_req_opcode);
        end else begin
          e = exp_mem.pop_front();
          check("mem_addr", mem_req_addr, e.addr);
          check("mem_op", mem_req_opcode, e.op);
          if (e.chk) check("mem_wdata", mem_req_store_data[e.sb*128 +: 128], e.data);
        end
      end else if (!mem_block) begin
        cnt++;
        if (cnt == 3) begin
          a = mem_req_addr;
          if (mem_req_opcode == MEM_SW) mem_model[a] = mem_req_store_data;
          else mem_rsp_load_data = mem_model.exists(a) ? mem_model[a] : pattern(a);
          mem_rsp_valid = 1;
          seen = 0;
        end
      end
    end
  end

  initial begin : rsp_mon
    rsp_t e;
    forever begin
      @(negedge clk);
      if (l1d_rsp_valid && l1i_rsp_valid) begin
        checks++;
        errors++;
        $display("FAIL rsp_onehot got d=1 i=1 expected at most one");
      end else if (l1d_rsp_valid || l1i_rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected got d=%0b i=%0b expected none", l1d_rsp_valid, l1i_rsp_valid);
        end else begin
          e = exp_rsp.pop_front();
          check("rsp_is_l1d", l1d_rsp_valid, e.d);
          if (e.chk) check("rsp_data", l1_mem_load_data, e.data);
        end
      end
      if (flush_complete) fc_cnt++;
    end
  end

  task automatic send(input logic d, input logic [31:0] a, input logic [3:0] op, input logic [127:0] wd);
    @(negedge clk);
    if (d) begin
      l1d_req = 1; l1d_addr = a; l1d_opcode = op; l1_mem_req_store_data = wd;
    end else begin
      l1i_req = 1; l1i_addr = a;
    end
    @(negedge clk);
    l1d_req = 0;
    l1i_req = 0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || exp_mem.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n == 3000) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got rsp=%0d mem=%0d outstanding expected 0", name, exp_rsp.size(), exp_mem.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin : main
    int n;
    repeat (3) @(negedge clk);
    check("reset_outputs", {mem_req_valid, l1_mem_req_ack, l1d_rsp_valid, l1i_rsp_valid, flush_complete,
                            mem_req_opcode, mem_req_addr, l1_mem_load_data}, 0);
    check("reset_counters", {cache_accesses, cache_hits}, 0);
    reset = 1;
    repeat (2) @(negedge clk);
    // cold read from L1I
    exp_m(32'h1000, MEM_LW, 0, 0, 0);
    exp_r(0, 1, SB0_1000);
    send(0, 32'h1000, MEM_LW, 0);
    drain("cold_read");
    check("cold_accesses", cache_accesses, 1);
    check("cold_hits", cache_hits, 0);
    // L1D read hit with ack/response timing
    exp_r(1, 1, SB1_1000);
    @(negedge clk);
    l1d_req = 1; l1d_addr = 32'h1010; l1d_opcode = MEM_LW;
    @(negedge clk);
    l1d_req = 0;
    n = 0;
    while (!l1_mem_req_ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("hit_ack_latency", n, 0);
    @(negedge clk);
    check("hit_rsp_n1", l1d_rsp_valid, 0);
    @(negedge clk);
    check("hit_rsp_n2", l1d_rsp_valid, 1);
    drain("hit");
    check("hit_hits", cache_hits, 1);
    // write hit, then conflicting read evicts the dirty line
    exp_r(1, 0, 0);
    send(1, 32'h1020, MEM_SW, AA);
    drain("write_hit");
    exp_m(32'h1000, MEM_SW, 1, 2, AA);
    exp_m(32'h5000, MEM_LW, 0, 0, 0);
    exp_r(1, 1, SB0_5000);
    send(1, 32'h5000, MEM_LW, 0);
    drain("evict");
    exp_m(32'h1000, MEM_LW, 0, 0, 0);
    exp_r(1, 1, AA);
    send(1, 32'h1020, MEM_LW, 0);
    drain("refetch");
    check("evict_hits", cache_hits, 2);
    // same-cycle requests: L1D hit served before L1I miss
    exp_m(32'h2000, MEM_LW, 0, 0, 0);
    exp_r(1, 1, SB3_1000);
    exp_r(0, 1, SB0_2000);
    @(negedge clk);
    l1d_req = 1; l1d_addr = 32'h1030; l1d_opcode = MEM_LW;
    l1i_req = 1; l1i_addr = 32'h2000;
    @(negedge clk);
    l1d_req = 0;
    l1i_req = 0;
    drain("arbitration");
    // dirty two lines, then flush
    exp_r(1, 0, 0);
    send(1, 32'h2010, MEM_SW, BB);
    exp_m(32'h3000, MEM_LW, 0, 0, 0);
    exp_r(1, 0, 0);
    send(1, 32'h3000, MEM_SW, CC);
    drain("dirty_setup");
    @(negedge clk);
    l1d_flush_req = 1; l1i_flush_req = 1;
    @(negedge clk);
    l1d_flush_req = 0; l1i_flush_req = 0;
    repeat (5) @(negedge clk);
    check("flush_wait_both", {mem_req_valid, 32'(fc_cnt)}, 0);
    l1i_flush_complete = 1;
    @(negedge clk);
    l1i_flush_complete = 0;
    repeat (4) @(negedge clk);
    check("flush_wait_d", {mem_req_valid, 32'(fc_cnt)}, 0);
    exp_m(32'h2000, MEM_SW, 1, 1, BB);
    exp_m(32'h3000, MEM_SW, 1, 0, CC);
    l1d_flush_complete = 1;
    @(negedge clk);
    l1d_flush_complete = 0;
    n = 0;
    while (fc_cnt == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    check("flush_pulses", fc_cnt, 1);
    check("flush_wb_left", exp_mem.size(), 0);
    exp_m(32'h1000, MEM_LW, 0, 0, 0);
    exp_r(0, 1, SB0_1000);
    send(0, 32'h1000, MEM_LW, 0);
    drain("post_flush");
    check("final_accesses", cache_accesses, 10);
    check("final_hits", cache_hits, 4);
    // reset while waiting for a fill
    mem_block = 1;
    exp_m(32'h4000, MEM_LW, 0, 0, 0);
    send(0, 32'h4000, MEM_LW, 0);
    n = 0;
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fill_pending", mem_req_valid, 1);
    repeat (2) @(negedge clk);
    #2 reset = 0;
    #1;
    check("rst_mid_outputs", {mem_req_valid, l1_mem_req_ack, l1d_rsp_valid, l1i_rsp_valid, mem_req_addr, mem_req_opcode}, 0);
    check("rst_mid_counters", {cache_accesses, cache_hits}, 0);
    @(negedge clk);
    reset = 1;
    mem_block = 0;
    exp_m(32'h1000, MEM_LW, 0, 0, 0);
    exp_r(0, 1, SB0_1000);
    send(0, 32'h1000, MEM_LW, 0);
    drain("after_reset");
    check("rst_accesses", cache_accesses, 1);
    check("rst_hits", cache_hits, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
